// File: rtl/led_fade_pkg.sv
// led_fade_pkg: shared constants and types for the LED fade source.
// Holds register map, CTRL/STATUS bit positions, FSM state type, colour type,
// and a byte-lane merge helper used by the register file.
package led_fade_pkg;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_COLOR_A  = 3'd1;
  localparam logic [2:0] ADDR_COLOR_B  = 3'd2;
  localparam logic [2:0] ADDR_STEP_DIV = 3'd3;
  localparam logic [2:0] ADDR_STATUS   = 3'd4;

  localparam int CTRL_RUN_BIT  = 0;
  localparam int CTRL_PP_BIT   = 1;
  localparam int STAT_BUSY_BIT = 31;
  localparam int STAT_DONE_BIT = 30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FADE = 2'd1,
    ST_DONE = 2'd2
  } fade_state_t;

  typedef logic [23:0] color_t;

  // Merge the low three write-data bytes into a 24-bit register, lane by lane.
  function automatic color_t be_merge(input color_t old_v, input logic [31:0] wdata,
                                      input logic [3:0] be);
    color_t v;
    v = old_v;
    for (int i = 0; i < 3; i++) begin
      if (be[i]) v[8*i +: 8] = wdata[8*i +: 8];
    end
    return v;
  endfunction

endpackage

// File: rtl/led_fade_chan.sv
// led_fade_chan: one 8-bit colour channel stepping one count toward its target.
// Load has priority over step; o_next_at_tgt says the value after a step would
// equal the target, letting the top detect end-of-leg in the tick cycle.
module led_fade_chan (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_step,
  input  logic [7:0] i_tgt,
  output logic [7:0] o_cur,
  output logic       o_next_at_tgt
);

  logic [7:0] r_cur;
  logic [7:0] w_next;

  // Next value moves one toward the target; equal holds, so 0/255 never wrap.
  always_comb begin
    w_next = r_cur;
    if (r_cur < i_tgt)      w_next = r_cur + 8'd1;
    else if (r_cur > i_tgt) w_next = r_cur - 8'd1;
  end

  assign o_next_at_tgt = (w_next == i_tgt);
  assign o_cur         = r_cur;

  // Current channel value: loaded at start, advanced on each step tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_cur <= 8'd0;
    else if (i_load) r_cur <= i_load_val;
    else if (i_step) r_cur <= w_next;
  end

endmodule

// File: rtl/led_fade_source.sv
// led_fade_source: Avalon-MM configured RGB fader emitting an Avalon-ST colour stream.
// Start beat one clock after the CTRL write; step beats every STEP_DIV+1 clocks.
// Source has no ready: each beat is a single-cycle valid pulse, data holds between beats.
module led_fade_source
  import led_fade_pkg::*;
#(
  parameter logic [23:0] DEFAULT_DIV = 24'd49999
) (
  input  logic        rsi_MRST_reset,
  input  logic        csi_MCLK_clk,
  input  logic [2:0]  avs_ctrl_address,
  input  logic [31:0] avs_ctrl_writedata,
  output logic [31:0] avs_ctrl_readdata,
  input  logic [3:0]  avs_ctrl_byteenable,
  input  logic        avs_ctrl_write,
  input  logic        avs_ctrl_read,
  output logic        avs_ctrl_waitrequest,
  output logic [23:0] aso_ledf_data,
  output logic        aso_ledf_valid
);

  logic        r_run;
  logic        r_pingpong;
  logic        r_done;
  logic        r_tgt_sel;      // 0: heading to COLOR_A, 1: heading to COLOR_B
  logic        r_valid;
  color_t      r_color_a;
  color_t      r_color_b;
  logic [23:0] r_step_div;
  logic [23:0] r_div_cnt;
  fade_state_t r_state;

  logic        w_wr_ctrl;
  logic        w_wr_div;
  logic        w_start;
  logic        w_wrap;
  logic        w_tick;
  logic        w_leg_end;
  logic [2:0]  w_at_tgt;
  color_t      w_cur;
  color_t      w_tgt;
  logic        w_unused;

  // Reads are side-effect free, so the read strobe carries no information.
  assign w_unused = avs_ctrl_read;

  assign avs_ctrl_waitrequest = 1'b0;

  assign w_wr_ctrl = avs_ctrl_write && (avs_ctrl_address == ADDR_CTRL) && avs_ctrl_byteenable[0];
  assign w_wr_div  = avs_ctrl_write && (avs_ctrl_address == ADDR_STEP_DIV) &&
                     (|avs_ctrl_byteenable[2:0]);
  assign w_start   = w_wr_ctrl && avs_ctrl_writedata[CTRL_RUN_BIT] && (r_state != ST_FADE);
  assign w_wrap    = (r_div_cnt == r_step_div);
  // A CTRL or STEP_DIV write in the wrap cycle swallows that tick entirely.
  assign w_tick    = (r_state == ST_FADE) && w_wrap && !w_wr_ctrl && !w_wr_div;
  // Target is the live colour register, so mid-fade edits apply at the next tick.
  assign w_tgt     = r_tgt_sel ? r_color_b : r_color_a;
  assign w_leg_end = &w_at_tgt;

  for (genvar g = 0; g < 3; g++) begin : g_chan
    led_fade_chan u_chan (
      .i_clk         (csi_MCLK_clk),
      .i_rst         (rsi_MRST_reset),
      .i_load        (w_start),
      .i_load_val    (r_color_a[8*g +: 8]),
      .i_step        (w_tick),
      .i_tgt         (w_tgt[8*g +: 8]),
      .o_cur         (w_cur[8*g +: 8]),
      .o_next_at_tgt (w_at_tgt[g])
    );
  end

  assign aso_ledf_data  = w_cur;
  assign aso_ledf_valid = r_valid;

  // Zero-latency register readback decoded from the address alone.
  always_comb begin
    avs_ctrl_readdata = 32'd0;
    case (avs_ctrl_address)
      ADDR_CTRL: begin
        avs_ctrl_readdata[CTRL_RUN_BIT] = r_run;
        avs_ctrl_readdata[CTRL_PP_BIT]  = r_pingpong;
      end
      ADDR_COLOR_A:  avs_ctrl_readdata[23:0] = r_color_a;
      ADDR_COLOR_B:  avs_ctrl_readdata[23:0] = r_color_b;
      ADDR_STEP_DIV: avs_ctrl_readdata[23:0] = r_step_div;
      ADDR_STATUS: begin
        avs_ctrl_readdata[STAT_BUSY_BIT] = (r_state == ST_FADE);
        avs_ctrl_readdata[STAT_DONE_BIT] = r_done;
        avs_ctrl_readdata[23:0]          = w_cur;
      end
      default: avs_ctrl_readdata = 32'd0;
    endcase
  end

  // Colour and divider configuration registers with per-byte write enables.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_color_a  <= 24'd0;
      r_color_b  <= 24'd0;
      r_step_div <= DEFAULT_DIV;
    end else if (avs_ctrl_write) begin
      case (avs_ctrl_address)
        ADDR_COLOR_A:  r_color_a  <= be_merge(r_color_a, avs_ctrl_writedata, avs_ctrl_byteenable);
        ADDR_COLOR_B:  r_color_b  <= be_merge(r_color_b, avs_ctrl_writedata, avs_ctrl_byteenable);
        ADDR_STEP_DIV: r_step_div <= be_merge(r_step_div, avs_ctrl_writedata, avs_ctrl_byteenable);
        default: ;
      endcase
    end
  end

  // Step divider: free-runs 0..STEP_DIV in FADE, restarts on start or a new divisor.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_div_cnt <= 24'd0;
    end else if (w_start || w_wr_div || ((r_state == ST_FADE) && w_wrap)) begin
      r_div_cnt <= 24'd0;
    end else if (r_state == ST_FADE) begin
      r_div_cnt <= r_div_cnt + 24'd1;
    end
  end

  // Fade FSM with CTRL register, DONE flag, leg direction and the beat strobe.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_state    <= ST_IDLE;
      r_run      <= 1'b0;
      r_pingpong <= 1'b0;
      r_done     <= 1'b0;
      r_tgt_sel  <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_wr_ctrl) begin
        r_pingpong <= avs_ctrl_writedata[CTRL_PP_BIT];
        r_run      <= avs_ctrl_writedata[CTRL_RUN_BIT];
        if (w_start) begin
          r_state   <= ST_FADE;
          r_tgt_sel <= 1'b1;
          r_done    <= 1'b0;
          r_valid   <= 1'b1;
        end else if ((r_state == ST_FADE) && !avs_ctrl_writedata[CTRL_RUN_BIT]) begin
          r_state <= ST_IDLE;
        end
      end else if (w_tick) begin
        r_valid <= 1'b1;
        if (w_leg_end) begin
          if (r_pingpong) begin
            r_tgt_sel <= ~r_tgt_sel;
          end else begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_run   <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_led_fade_source.sv
// Bench for led_fade_source: directed register/fade scenarios with a closed-form
// colour model checked against the stream on every clock, plus literal checks.
module tb_led_fade_source;

  logic        rst;
  logic        clk;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  byteenable;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [23:0] ledf_data;
  logic        ledf_valid;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model state: mode 0 = static colour, no beats; mode 1 = fade started at edge m_e.
  int          m_mode   = 0;
  int          m_e      = 0;
  int          m_div    = 0;
  bit          m_pp     = 0;
  logic [23:0] m_a      = 24'd0;
  logic [23:0] m_b      = 24'd0;
  logic [23:0] m_static = 24'd0;

  bit          cap_en = 0;
  logic [23:0] beat_q[$];

  led_fade_source dut (
    .rsi_MRST_reset       (rst),
    .csi_MCLK_clk         (clk),
    .avs_ctrl_address     (address),
    .avs_ctrl_writedata   (writedata),
    .avs_ctrl_readdata    (readdata),
    .avs_ctrl_byteenable  (byteenable),
    .avs_ctrl_write       (write),
    .avs_ctrl_read        (read),
    .avs_ctrl_waitrequest (waitrequest),
    .aso_ledf_data        (ledf_data),
    .aso_ledf_valid       (ledf_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int absdiff(input int x, input int y);
    return (x > y) ? x - y : y - x;
  endfunction

  // Leg length in ticks: the largest per-channel distance.
  function automatic int leg_len(input logic [23:0] a, input logic [23:0] b);
    int l;
    l = 0;
    for (int c = 0; c < 3; c++) begin
      if (absdiff(int'(a[8*c +: 8]), int'(b[8*c +: 8])) > l)
        l = absdiff(int'(a[8*c +: 8]), int'(b[8*c +: 8]));
    end
    return l;
  endfunction

  // Colour after k ticks: legs alternate A->B, B->A; each channel walks min(j, dist).
  function automatic logic [23:0] model_color(input logic [23:0] a, input logic [23:0] b,
                                              input int k, input bit pp);
    int l, leg, j, f, t, s;
    logic [23:0] from, to, r;
    l = leg_len(a, b);
    if (l == 0) return a;
    if (!pp) begin
      leg = 0;
      j   = (k > l) ? l : k;
    end else if (k == 0) begin
      leg = 0;
      j   = 0;
    end else begin
      leg = (k - 1) / l;
      j   = k - leg * l;
    end
    from = (leg % 2 == 1) ? b : a;
    to   = (leg % 2 == 1) ? a : b;
    r    = 24'd0;
    for (int c = 0; c < 3; c++) begin
      f = int'(from[8*c +: 8]);
      t = int'(to[8*c +: 8]);
      s = (j < absdiff(f, t)) ? j : absdiff(f, t);
      r[8*c +: 8] = 8'((t >= f) ? f + s : f - s);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write is presented from a falling edge and sampled at the next rising edge;
  // e returns the number of that rising edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be,
                           output int e);
    @(negedge clk);
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    @(posedge clk);
    #1;
    e          = cyc;
    write      = 1'b0;
    byteenable = 4'h0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    #1;
    d       = readdata;
    read    = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stream check on every falling edge against the model.
  always @(negedge clk) begin
    int d, p, k;
    logic ev;
    logic [23:0] ed;
    if (m_mode == 1) begin
      d  = cyc - m_e;
      p  = m_div + 1;
      k  = d / p;
      ev = (d >= 0) && (d % p == 0) && (m_pp || k <= leg_len(m_a, m_b));
      ed = model_color(m_a, m_b, k, m_pp);
    end else begin
      ev = 1'b0;
      ed = m_static;
    end
    check("stream_valid", {31'd0, ledf_valid}, {31'd0, ev});
    check("stream_data", {8'd0, ledf_data}, {8'd0, ed});
    if (cap_en && ledf_valid) beat_q.push_back(ledf_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e, s;
    logic [23:0] exp_beats[4];
    rst        = 1'b1;
    address    = 3'd0;
    writedata  = 32'd0;
    byteenable = 4'h0;
    write      = 1'b0;
    read       = 1'b0;

    // The model itself, pinned by hand-computed values.
    check("model_os_k1", {8'd0, model_color(24'h000000, 24'h030201, 1, 0)}, 32'h010101);
    check("model_os_k2", {8'd0, model_color(24'h000000, 24'h030201, 2, 0)}, 32'h020201);
    check("model_os_k9", {8'd0, model_color(24'h000000, 24'h030201, 9, 0)}, 32'h030201);
    check("model_pp_k4", {8'd0, model_color(24'h000000, 24'h030201, 4, 1)}, 32'h020100);
    check("model_pp_k6", {8'd0, model_color(24'h000000, 24'h030201, 6, 1)}, 32'h000000);
    check("model_pp_k7", {8'd0, model_color(24'h000000, 24'h030201, 7, 1)}, 32'h010101);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset values and unmapped addresses.
    check("waitrequest", {31'd0, waitrequest}, 32'd0);
    check_reg("rst_ctrl",   3'd0, 32'd0);
    check_reg("rst_col_a",  3'd1, 32'd0);
    check_reg("rst_col_b",  3'd2, 32'd0);
    check_reg("rst_div",    3'd3, 32'd49999);
    check_reg("rst_status", 3'd4, 32'd0);
    check_reg("rd_addr5",   3'd5, 32'd0);
    check_reg("rd_addr7",   3'd7, 32'd0);
    repeat (5) @(posedge clk);
    #1;

    // Byte-lane write: only the green lane lands.
    bus_write(3'd1, 32'hFFFF_FFFF, 4'b0010, e);
    check_reg("be_col_a", 3'd1, 32'h0000FF00);
    bus_write(3'd1, 32'h0000_0000, 4'hF, e);
    bus_write(3'd2, 32'h0003_0201, 4'hF, e);
    bus_write(3'd3, 32'h0000_0001, 4'hF, e);
    check_reg("cfg_col_b", 3'd2, 32'h00030201);
    check_reg("cfg_div",   3'd3, 32'd1);
    m_a   = 24'h000000;
    m_b   = 24'h030201;
    m_div = 1;

    // One-shot fade.
    cap_en = 1'b1;
    bus_write(3'd0, 32'h1, 4'h1, e);
    m_mode = 1; m_e = e; m_pp = 0;
    check_reg("os_busy", 3'd4, 32'h80000000);
    wait_to(e + 12);
    cap_en = 1'b0;
    exp_beats = '{24'h000000, 24'h010101, 24'h020201, 24'h030201};
    check("os_beat_count", beat_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < beat_q.size()) check("os_beat", {8'd0, beat_q[i]}, {8'd0, exp_beats[i]});
    end
    check_reg("os_status", 3'd4, 32'h40030201);
    check_reg("os_ctrl",   3'd0, 32'd0);

    // Ping-pong, started from DONE; then stop.
    bus_write(3'd0, 32'h3, 4'h1, e);
    m_mode = 1; m_e = e; m_pp = 1;
    check_reg("pp_ctrl", 3'd0, 32'd3);
    wait_to(e + 16);
    check_reg("pp_status", 3'd4, 32'h80020201);
    bus_write(3'd0, 32'h0, 4'h1, s);
    m_mode   = 0;
    m_static = model_color(m_a, m_b, (s - 1 - e) / (m_div + 1), 1);
    repeat (6) @(posedge clk);
    #1;
    check_reg("pp_stop_status", 3'd4, {8'd0, m_static});

    // One-shot stopped after two step beats.
    bus_write(3'd0, 32'h1, 4'h1, e);
    m_mode = 1; m_e = e; m_pp = 0;
    wait_to(e + 4);
    bus_write(3'd0, 32'h0, 4'h1, s);
    m_mode   = 0;
    m_static = model_color(m_a, m_b, (s - 1 - e) / (m_div + 1), 0);
    repeat (8) @(posedge clk);
    #1;
    check_reg("stop_status", 3'd4, 32'h00020201);
    check_reg("stop_ctrl",   3'd0, 32'd0);

    // Asynchronous reset in the middle of a beat.
    bus_write(3'd0, 32'h3, 4'h1, e);
    m_mode = 1; m_e = e; m_pp = 1;
    wait_to(e + 2);
    #1;
    check("pre_reset_valid", {31'd0, ledf_valid}, 32'd1);
    rst      = 1'b1;
    m_mode   = 0;
    m_static = 24'd0;
    #1;
    check("reset_valid_now", {31'd0, ledf_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reg("rst2_ctrl",   3'd0, 32'd0);
    check_reg("rst2_col_a",  3'd1, 32'd0);
    check_reg("rst2_col_b",  3'd2, 32'd0);
    check_reg("rst2_div",    3'd3, 32'd49999);
    check_reg("rst2_status", 3'd4, 32'd0);
    repeat (4) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/led_fade_source.md
# led_fade_source

Avalon-ST source that produces the 24-bit RGB colour stream consumed by the LED PWM block's `ledf` sink. It is configured over an Avalon-MM slave and generates linear per-channel fades from colour A to colour B, one-shot or ping-pong, emitting one `valid` beat per fade step. It sits in the Qsys system between the CPU bus and the LED PWM block, and removes per-step CPU writes during colour animation.

## Interface
- DEFAULT_DIV, 24'd49999 — reset value of STEP_DIV (clocks per step minus 1).
- rsi_MRST_reset  in  1  reset, asynchronous, active-high.
- csi_MCLK_clk  in  1  clock.
- avs_ctrl_address  in  3  word address.
- avs_ctrl_writedata  in  32  write data.
- avs_ctrl_readdata  out  32  read data, combinational from address, zero read latency.
- avs_ctrl_byteenable  in  4  byte lanes; a byte is written only if its bit is set.
- avs_ctrl_write  in  1  write strobe.
- avs_ctrl_read  in  1  read strobe; reads have no side effects.
- avs_ctrl_waitrequest  out  1  tied 0.
- aso_ledf_data  out  24  {R[23:16], G[15:8], B[7:0]} current colour.
- aso_ledf_valid  out  1  one-cycle beat; no ready, no backpressure.

## Operation
- Registers:
  - 0 CTRL: bit0 RUN, bit1 PINGPONG. Read/write.
  - 1 COLOR_A[23:0]. Read/write.
  - 2 COLOR_B[23:0]. Read/write.
  - 3 STEP_DIV[23:0]. Read/write.
  - 4 STATUS, read-only: bit31 BUSY, bit30 DONE, [23:0] current colour.
  - Unused bits and addresses 5-7 read 0; writes to them are ignored.
- Reset values: CTRL, COLOR_A, COLOR_B, current colour and DONE are 0; STEP_DIV = DEFAULT_DIV; state IDLE; aso_ledf_valid 0; aso_ledf_data 0.
- States:
  - IDLE: BUSY=0.
  - FADE: BUSY=1.
  - DONE: BUSY=0, DONE=1.
- Start: a write to CTRL with byteenable[0]=1 and RUN=1 while the state is not FADE does all of the following:
  - cur <= COLOR_A, tgt_sel <= B, DONE <= 0.
  - Clears the divider.
  - Enters FADE and emits a beat carrying COLOR_A.
- Step tick: the divider counts 0..STEP_DIV and ticks on wrap, only in FADE. On each tick:
  - Each channel moves 1 toward its target (the target is the live COLOR_A/COLOR_B selected by tgt_sel).
  - A channel already equal to its target holds.
  - One beat is emitted carrying the new cur.
  - Arithmetic is 8-bit unsigned per channel and never wraps (0 and 255 saturate by construction).
- End of leg: when cur equals the target after a tick:
  - PINGPONG=1: toggle tgt_sel and stay in FADE.
  - PINGPONG=0: go to DONE, set DONE, clear RUN.
- Stop: writing RUN=0 in FADE returns to IDLE. cur holds, no further beats are emitted, DONE is unchanged.
- COLOR_A/B written mid-fade: the new value takes effect at the next tick. Direction is re-evaluated per channel at each tick.
- STEP_DIV written mid-fade: the divider restarts at 0.
- Simultaneous CTRL write and tick in the same cycle: the write wins and no beat is emitted for that tick.
- Start while already in FADE with RUN=1: no restart (a rewrite of CTRL only updates PINGPONG).

## Timing
- The beat is registered: a start write in cycle N gives valid=1 in cycle N+1 with data = COLOR_A.
- Step beats are spaced exactly STEP_DIV+1 clocks apart; the first step beat follows STEP_DIV+1 clocks after the start beat.
- aso_ledf_data holds cur between beats. valid is high for exactly one cycle per beat.
- A leg lasts max(|ΔR|,|ΔG|,|ΔB|) ticks; at most 255.
- STATUS reflects a register update in the cycle after it.
- Reset asserted mid-fade: valid drops to 0 immediately (asynchronous), and all state returns to reset values.

## Structure
- Package led_fade_pkg:
  - Register address constants.
  - CTRL/STATUS bit positions.
  - State enum {IDLE, FADE, DONE}.
  - 24-bit colour type.
- Sub-module led_fade_chan: 8-bit cur/target stepper with an at-target flag, instantiated three times.
- Top level holds the register file, divider, FSM and beat register.

## Test plan
- Reset, then read addresses 0-4 -> 0, 0, 0, DEFAULT_DIV, 0; valid stays 0 with no writes.
- A=0x000000, B=0x030201, DIV=1, start -> beats 000000, 010101, 020201, 030201, each 2 clocks apart; then DONE=1, BUSY=0, RUN reads 0.
- Same setup with PINGPONG=1 -> after 030201 the beats continue 020100, 010000, 000000, then climb again; BUSY stays 1.
- Stop mid-fade: write RUN=0 after 2 beats -> no further valid; STATUS[23:0] holds 020201 (per the test-2 sequence).
- Byte-enable: write 0xFFFFFFFF to COLOR_A with byteenable=4'b0010 -> COLOR_A reads 0x00FF00.
- Assert reset mid-fade -> valid is 0 in the same cycle, and all registers read their reset values.
